// File: rtl/game_pkg.sv
// Shared constants, state encoding and velocity type for the game sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    localparam int VEL_W = 6;
    typedef logic signed [VEL_W-1:0] vel_t;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;
    localparam int BIRD_WIDTH    = 34;
    localparam int BIRD_HEIGHT   = 24;
    localparam int PIPE_WIDTH    = 52;
    localparam int BIRD_X        = 303;
    localparam int BIRD_START_Y  = 228;
    localparam int FLOOR_Y       = 456;
    localparam int BIRD_MAX_Y    = FLOOR_Y - BIRD_HEIGHT;
    localparam int PIPE_SPEED    = 2;
    localparam int PIPE_GAP      = 120;
    localparam int GAP_RESET_Y   = 160;
    localparam int GAP_BASE_Y    = 64;
    localparam int DEATH_FRAMES  = 60;

    localparam vel_t GRAVITY      = 6'sd1;
    localparam vel_t FLAP_VEL     = -6'sd8;
    localparam vel_t MAX_FALL_VEL = 6'sd10;

    localparam logic [7:0] LFSR_SEED = 8'hA5;

endpackage

// File: rtl/game_lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, loaded with seed on reset.
// Latency: advances one step per enabled clock.
// Backpressure: none; en simply holds the sequence.
module game_lfsr8 (
    input  logic       core_clk,
    input  logic       rst,
    input  logic [7:0] seed,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge core_clk) begin
        if (rst) begin
            q <= seed;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/game_physics_controller.sv
// Per-frame bird physics, pipe scroll, scoring and play/death/restart sequencing; pipes built with GAME_PIPES_EN.
// Latency: registered outputs change the cycle after iFrameTick; flap edges pend until the next tick.
// Backpressure: none; every tick, including back-to-back ticks, applies a full update.
module game_physics_controller
    import game_pkg::*;
(
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iFrameTick,
    input  logic        iFlap,
    output logic [9:0]  oBirdY,
    output logic [15:0] oScore,
    output logic [9:0]  oPipeX,
    output logic [8:0]  oPipeGapY,
    output logic [1:0]  oState
);

    game_state_t state, state_n;
    logic [9:0]  bird_y, bird_y_n;
    vel_t        vel, vel_n;
    logic [15:0] score, score_n;
    logic [9:0]  pipe_x, pipe_x_n;
    logic [8:0]  gap_y, gap_y_n;
    logic [5:0]  death_cnt, death_cnt_n;

    logic flap_q, flap_pend, flap_now;

    // An edge in the same cycle as a tick is folded straight into that tick.
    assign flap_now = flap_pend | (iFlap & ~flap_q);

    always_ff @(posedge iClock) begin
        if (iReset) begin
            flap_q    <= 1'b0;
            flap_pend <= 1'b0;
        end else begin
            flap_q    <= iFlap;
            flap_pend <= iFrameTick ? 1'b0 : flap_now;
        end
    end

    vel_t               vel_fall, vel_step, vel_phys;
    logic signed [10:0] y_sum;
    logic [9:0]         y_phys;
    logic               floor_hit;

    always_comb begin
        vel_fall  = (vel >= MAX_FALL_VEL) ? MAX_FALL_VEL : vel + GRAVITY;
        vel_step  = (flap_now && state != ST_DYING) ? FLAP_VEL : vel_fall;
        y_sum     = $signed({1'b0, bird_y}) + $signed({{(11-VEL_W){vel_step[VEL_W-1]}}, vel_step});
        y_phys    = y_sum[9:0];
        vel_phys  = vel_step;
        floor_hit = 1'b0;
        if (y_sum[10]) begin
            y_phys   = '0;
            vel_phys = '0;
        end else if (y_sum[9:0] > 10'(BIRD_MAX_Y)) begin
            y_phys    = 10'(BIRD_MAX_Y);
            floor_hit = 1'b1;
        end
    end

    logic [9:0] pipe_step_x;
    logic [8:0] pipe_step_gap;
    logic       passed, collide;

`ifdef GAME_PIPES_EN
    localparam logic [8:0] GAP_INIT = 9'(GAP_RESET_Y);

    logic [7:0]  lfsr;
    logic [10:0] right_old, right_new;

    game_lfsr8 u_lfsr (
        .core_clk (iClock),
        .rst      (iReset),
        .seed     (LFSR_SEED),
        .en       (1'b1),
        .q        (lfsr)
    );

    always_comb begin
        pipe_step_x   = pipe_x - 10'(PIPE_SPEED);
        pipe_step_gap = gap_y;
        if (pipe_x < 10'(PIPE_SPEED)) begin
            pipe_step_x   = 10'(SCREEN_WIDTH);
            pipe_step_gap = 9'(GAP_BASE_Y) + {1'b0, lfsr};
        end
        right_old = {1'b0, pipe_x} + 11'(PIPE_WIDTH);
        right_new = {1'b0, pipe_step_x} + 11'(PIPE_WIDTH);
        passed    = (right_old >= 11'(BIRD_X)) && (right_new < 11'(BIRD_X));
        collide   = (pipe_step_x < 10'(BIRD_X + BIRD_WIDTH)) && (right_new > 11'(BIRD_X))
                 && (({1'b0, y_phys} < {2'b0, pipe_step_gap})
                  || ({1'b0, y_phys} + 11'(BIRD_HEIGHT) > {2'b0, pipe_step_gap} + 11'(PIPE_GAP)));
    end
`else
    localparam logic [8:0] GAP_INIT = '0;

    assign pipe_step_x   = 10'(SCREEN_WIDTH);
    assign pipe_step_gap = '0;
    assign passed        = 1'b0;
    assign collide       = 1'b0;
`endif

    always_comb begin
        state_n     = state;
        bird_y_n    = bird_y;
        vel_n       = vel;
        score_n     = score;
        pipe_x_n    = pipe_x;
        gap_y_n     = gap_y;
        death_cnt_n = death_cnt;
        case (state)
            ST_IDLE, ST_PLAY: begin
                if (state == ST_PLAY || flap_now) begin
                    state_n  = ST_PLAY;
                    bird_y_n = y_phys;
                    vel_n    = vel_phys;
                    pipe_x_n = pipe_step_x;
                    gap_y_n  = pipe_step_gap;
                    if (passed && !collide && score != 16'hFFFF) begin
                        score_n = score + 16'd1;
                    end
                    if (floor_hit || collide) begin
                        state_n     = ST_DYING;
                        death_cnt_n = '0;
                    end
                end
            end
            ST_DYING: begin
                bird_y_n = y_phys;
                vel_n    = vel_phys;
                if (death_cnt == 6'(DEATH_FRAMES - 1)) begin
                    state_n = ST_OVER;
                end else begin
                    death_cnt_n = death_cnt + 6'd1;
                end
            end
            ST_OVER: begin
                if (flap_now) begin
                    state_n  = ST_IDLE;
                    bird_y_n = 10'(BIRD_START_Y);
                    vel_n    = '0;
                    score_n  = '0;
                    pipe_x_n = 10'(SCREEN_WIDTH);
                    gap_y_n  = GAP_INIT;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state     <= ST_IDLE;
            bird_y    <= 10'(BIRD_START_Y);
            vel       <= '0;
            score     <= '0;
            pipe_x    <= 10'(SCREEN_WIDTH);
            gap_y     <= GAP_INIT;
            death_cnt <= '0;
        end else if (iFrameTick) begin
            state     <= state_n;
            bird_y    <= bird_y_n;
            vel       <= vel_n;
            score     <= score_n;
            pipe_x    <= pipe_x_n;
            gap_y     <= gap_y_n;
            death_cnt <= death_cnt_n;
        end
    end

    assign oBirdY    = bird_y;
    assign oScore    = score;
    assign oPipeX    = pipe_x;
    assign oPipeGapY = gap_y;
    assign oState    = state;

endmodule

// File: tb/tb_game_physics_controller.sv
// Directed vector table plus hand sequences for ceiling, collision, scoring and reset-on-tick.
module tb_game_physics_controller;

`ifdef GAME_PIPES_EN
    localparam bit PIPES = 1'b1;
`else
    localparam bit PIPES = 1'b0;
`endif
    localparam int EXP_GAP = PIPES ? 160 : 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_in = 1'b0;
    logic        flap_in = 1'b0;
    logic [9:0]  bird_y;
    logic [15:0] score;
    logic [9:0]  pipe_x;
    logic [8:0]  gap_y;
    logic [1:0]  state;

    int n_pass  = 0;
    int n_total = 0;

    game_physics_controller dut (
        .iClock     (clk),
        .iReset     (rst),
        .iFrameTick (tick_in),
        .iFlap      (flap_in),
        .oBirdY     (bird_y),
        .oScore     (score),
        .oPipeX     (pipe_x),
        .oPipeGapY  (gap_y),
        .oState     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pulses;
        int ticks;
        int st;
        int y;
        int px;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic flap_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            flap_in = 1'b1;
            cyc();
            flap_in = 1'b0;
            cyc();
        end
    endtask

    task automatic tick();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    int exp_px;

    initial begin
        // pulses, ticks, state, bird Y, pipe X (pipes build)
        vecs[0]  = '{0, 3,  0, 228, 640};
        vecs[1]  = '{3, 1,  1, 220, 638};
        vecs[2]  = '{0, 1,  1, 213, 636};
        vecs[3]  = '{0, 5,  1, 193, 626};
        vecs[4]  = '{0, 2,  1, 192, 622};
        vecs[5]  = '{0, 8,  1, 228, 606};
        vecs[6]  = '{1, 1,  1, 220, 604};
        vecs[7]  = '{0, 1,  1, 213, 602};
        vecs[8]  = '{0, 17, 1, 247, 568};
        vecs[9]  = '{0, 18, 1, 427, 532};
        vecs[10] = '{0, 1,  2, 432, 530};
        vecs[11] = '{1, 59, 2, 432, 530};
        vecs[12] = '{0, 1,  3, 432, 530};
        vecs[13] = '{0, 3,  3, 432, 530};
        vecs[14] = '{1, 1,  0, 228, 640};
        vecs[15] = '{0, 2,  0, 228, 640};

        do_reset();
        check("reset_state", int'(state), 0);
        check("reset_y", int'(bird_y), 228);
        check("reset_score", int'(score), 0);
        check("reset_pipe_x", int'(pipe_x), 640);
        check("reset_gap", int'(gap_y), EXP_GAP);

        for (int v = 0; v < 16; v++) begin
            flap_pulse(vecs[v].pulses);
            for (int t = 0; t < vecs[v].ticks; t++) tick();
            exp_px = PIPES ? vecs[v].px : 640;
            check($sformatf("vec%0d_state", v), int'(state), vecs[v].st);
            check($sformatf("vec%0d_y", v), int'(bird_y), vecs[v].y);
            check($sformatf("vec%0d_score", v), int'(score), 0);
            check($sformatf("vec%0d_pipe_x", v), int'(pipe_x), exp_px);
        end

        // Flap edge landing on the tick cycle itself, then reset coinciding with a tick.
        do_reset();
        flap_in = 1'b1;
        tick();
        flap_in = 1'b0;
        check("same_cycle_flap_state", int'(state), 1);
        check("same_cycle_flap_y", int'(bird_y), 220);
        tick();
        check("after_flap_y", int'(bird_y), 213);
        flap_pulse(1);
        rst = 1'b1;
        tick_in = 1'b1;
        cyc();
        rst = 1'b0;
        tick_in = 1'b0;
        check("rst_tick_state", int'(state), 0);
        check("rst_tick_y", int'(bird_y), 228);
        check("rst_tick_score", int'(score), 0);
        check("rst_tick_pipe_x", int'(pipe_x), 640);
        check("rst_tick_gap", int'(gap_y), EXP_GAP);
        tick();
        check("rst_clears_pending", int'(state), 0);

        // Climb into the ceiling, then sit there until the first pipe arrives.
        for (int n = 1; n <= 29; n++) begin
            flap_pulse(1);
            tick();
        end
        check("ceiling_y", int'(bird_y), 0);
        tick();
        check("ceiling_vel_zeroed", int'(bird_y), 1);
        for (int n = 31; n <= 151; n++) begin
            flap_pulse(1);
            tick();
        end
        check("pre_pipe_state", int'(state), 1);
        check("pre_pipe_y", int'(bird_y), 0);
        flap_pulse(1);
        tick();
        check("collide_state", int'(state), PIPES ? 2 : 1);
        check("collide_pipe_x", int'(pipe_x), PIPES ? 336 : 640);
        check("collide_score", int'(score), 0);
        check("collide_gap", int'(gap_y), EXP_GAP);
        tick();
        check("dying_pipe_frozen", int'(pipe_x), PIPES ? 336 : 640);
        check("dying_fall_y", int'(bird_y), 1);

        if (PIPES) begin
            // Keep the bird inside the 160..280 gap; the pass lands when X goes 252 -> 250.
            do_reset();
            flap_pulse(1);
            tick();
            for (int n = 2; n <= 200; n++) begin
                if (bird_y > 10'd230) flap_pulse(1);
                tick();
                if (n == 194) begin
                    check("score_x252_pipe_x", int'(pipe_x), 252);
                    check("score_before_pass", int'(score), 0);
                end
                if (n == 195) begin
                    check("score_x250_pipe_x", int'(pipe_x), 250);
                    check("score_on_pass", int'(score), 1);
                    check("score_on_pass_state", int'(state), 1);
                end
                if (n == 200) begin
                    check("score_after_pass", int'(score), 1);
                    check("score_after_pass_state", int'(state), 1);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
